// File: rtl/evacuate_and_depressurize.sv
// Airlock evacuation sequencer: door interlock, pump drive, debounced empty sensor.
// Optional stuck-evacuation timeout compiled in with EVAC_TIMEOUT_EN.
module evacuate_and_depressurize #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SETTLE_CYCLES  = 4,
  parameter int CNT_W          = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       begin_Evacuation,
  input  logic       InnerClosed,
  input  logic       OuterClosed,
  input  logic       Evacuated,
  output logic       Evacuate,
  output logic       EvacDone,
  output logic       Busy,
  output logic       Fault,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EVACUATING = 3'd1,
    SETTLE     = 3'd2,
    DONE       = 3'd3,
    FAULT      = 3'd4
  } state_e;

  if ((2 ** CNT_W) <= ((TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES))
  begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES/SETTLE_CYCLES");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d, settle_inc;
  logic             abort, timeout_hit;

  assign abort      = ~begin_Evacuation | ~InnerClosed | ~OuterClosed;
  assign settle_inc = (settle_q == '1) ? settle_q : settle_q + 1'b1;

`ifdef EVAC_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_q, tmo_d, tmo_inc;
  assign tmo_inc     = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
  assign timeout_hit = (tmo_inc >= CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
`ifdef EVAC_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (begin_Evacuation & InnerClosed & OuterClosed) begin
          state_d  = EVACUATING;
          settle_d = '0;
`ifdef EVAC_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end
      EVACUATING, SETTLE: begin
`ifdef EVAC_TIMEOUT_EN
        tmo_d = tmo_inc;
`endif
        if (abort || timeout_hit) begin
          state_d = FAULT;
        end else if (state_q == EVACUATING) begin
          settle_d = '0;
          if (Evacuated) state_d = SETTLE;
        end else if (!Evacuated) begin
          // Bounce restarts the debounce but not the overall timeout.
          state_d  = EVACUATING;
          settle_d = '0;
        end else begin
          settle_d = settle_inc;
          if (settle_inc >= CNT_W'(SETTLE_CYCLES)) state_d = DONE;
        end
      end
      DONE, FAULT: begin
        if (!begin_Evacuation) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as State.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
`ifdef EVAC_TIMEOUT_EN
      tmo_q    <= '0;
`endif
      Evacuate <= 1'b0;
      EvacDone <= 1'b0;
      Busy     <= 1'b0;
      Fault    <= 1'b0;
      State    <= 3'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
`ifdef EVAC_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
      Evacuate <= (state_d == EVACUATING) || (state_d == SETTLE);
      Busy     <= (state_d == EVACUATING) || (state_d == SETTLE);
      EvacDone <= (state_d == DONE);
      Fault    <= (state_d == FAULT);
      State    <= state_d;
    end
  end

endmodule

// File: tb/tb_evacuate_and_depressurize.sv
// Directed bench for evacuate_and_depressurize: vector table plus corner-case sequences.
module tb_evacuate_and_depressurize;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       begin_Evacuation = 1'b0;
  logic       InnerClosed = 1'b1;
  logic       OuterClosed = 1'b1;
  logic       Evacuated = 1'b0;
  logic       Evacuate, EvacDone, Busy, Fault;
  logic [2:0] State;

  int checks = 0;
  int failures = 0;

  // {Evacuate, EvacDone, Busy, Fault}
  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_ACT  = 4'b1010;
  localparam logic [3:0] O_DONE = 4'b0100;
  localparam logic [3:0] O_FLT  = 4'b0001;

  typedef struct {
    logic       b, i, o, e;
    logic [2:0] st;
    logic [3:0] outs;
  } vec_t;

  evacuate_and_depressurize dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .begin_Evacuation (begin_Evacuation),
    .InnerClosed      (InnerClosed),
    .OuterClosed      (OuterClosed),
    .Evacuated        (Evacuated),
    .Evacuate         (Evacuate),
    .EvacDone         (EvacDone),
    .Busy             (Busy),
    .Fault            (Fault),
    .State            (State)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [2:0] st, input logic [3:0] o);
    checks++;
    if ({State, Evacuate, EvacDone, Busy, Fault} !== {st, o}) begin
      failures++;
      $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b",
               nm, State, {Evacuate, EvacDone, Busy, Fault}, st, o);
    end
  endtask

  task automatic step(input logic b, input logic i, input logic o, input logic e);
    begin_Evacuation = b;
    InnerClosed      = i;
    OuterClosed      = o;
    Evacuated        = e;
    @(posedge Clock);
    #1;
  endtask

  function automatic vec_t mk(input logic b, input logic i, input logic o, input logic e,
                              input logic [2:0] st, input logic [3:0] outs);
    vec_t v;
    v.b = b; v.i = i; v.o = o; v.e = e; v.st = st; v.outs = outs;
    return v;
  endfunction

  vec_t nom[16];

  initial begin
    // Nominal run: row k is what edge k+1 samples and what must follow it.
    nom[0] = mk(0, 1, 1, 0, 3'd0, O_IDLE);
    nom[1] = mk(1, 1, 1, 0, 3'd1, O_ACT);
    for (int k = 2; k < 9; k++) nom[k] = mk(1, 1, 1, 0, 3'd1, O_ACT);
    nom[9]  = mk(1, 1, 1, 1, 3'd2, O_ACT);
    nom[10] = mk(1, 1, 1, 1, 3'd2, O_ACT);
    nom[11] = mk(1, 1, 1, 1, 3'd2, O_ACT);
    nom[12] = mk(1, 1, 1, 1, 3'd2, O_ACT);
    nom[13] = mk(1, 1, 1, 1, 3'd3, O_DONE);
    nom[14] = mk(1, 0, 0, 1, 3'd3, O_DONE);
    nom[15] = mk(0, 0, 0, 0, 3'd0, O_IDLE);

    #2 Reset = 1'b0;
    #1 chk("reset_state", 3'd0, O_IDLE);
    #5 Reset = 1'b1;

    for (int k = 0; k < 16; k++) begin
      step(nom[k].b, nom[k].i, nom[k].o, nom[k].e);
      chk($sformatf("nominal_edge%0d", k + 1), nom[k].st, nom[k].outs);
    end

    // Outer door open: request ignored, no fault.
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 0, 0);
      chk($sformatf("outer_open_%0d", k), 3'd0, O_IDLE);
    end
    step(0, 1, 1, 0);

    // Inner door opens mid-evacuation.
    step(1, 1, 1, 0); chk("intlk_start", 3'd1, O_ACT);
    step(1, 0, 1, 0); chk("intlk_fault", 3'd4, O_FLT);
    step(1, 1, 1, 0); chk("intlk_hold1", 3'd4, O_FLT);
    step(1, 1, 1, 1); chk("intlk_hold2", 3'd4, O_FLT);
    step(0, 1, 1, 0); chk("intlk_clear", 3'd0, O_IDLE);

    // Sensor bounce in SETTLE.
    step(1, 1, 1, 0); chk("bnc_evac", 3'd1, O_ACT);
    step(1, 1, 1, 1); chk("bnc_settle", 3'd2, O_ACT);
    step(1, 1, 1, 1); chk("bnc_good1", 3'd2, O_ACT);
    step(1, 1, 1, 1); chk("bnc_good2", 3'd2, O_ACT);
    step(1, 1, 1, 0); chk("bnc_drop", 3'd1, O_ACT);
    step(1, 1, 1, 1); chk("bnc_reenter", 3'd2, O_ACT);
    for (int k = 1; k < 4; k++) begin
      step(1, 1, 1, 1);
      chk($sformatf("bnc_not_done_%0d", k), 3'd2, O_ACT);
    end
    step(1, 1, 1, 1); chk("bnc_done", 3'd3, O_DONE);
    step(0, 1, 1, 1); chk("bnc_idle", 3'd0, O_IDLE);

    // Sensor already empty at request; then abort from SETTLE by dropping request.
    step(1, 1, 1, 1); chk("pre_evac_one_cycle", 3'd1, O_ACT);
    step(1, 1, 1, 1); chk("pre_evac_settle", 3'd2, O_ACT);
    step(0, 1, 1, 1); chk("req_drop_fault", 3'd4, O_FLT);
    step(0, 1, 1, 1); chk("req_drop_idle", 3'd0, O_IDLE);

    // Timeout / indefinite wait with the sensor stuck low.
    step(1, 1, 1, 0); chk("tmo_entry", 3'd1, O_ACT);
`ifdef EVAC_TIMEOUT_EN
    for (int k = 1; k < 64; k++) step(1, 1, 1, 0);
    chk("tmo_edge_minus1", 3'd1, O_ACT);
    step(1, 1, 1, 0); chk("tmo_fault", 3'd4, O_FLT);
`else
    for (int k = 1; k < 199; k++) step(1, 1, 1, 0);
    chk("no_tmo_still_evac", 3'd1, O_ACT);
    step(1, 0, 1, 0); chk("no_tmo_abort", 3'd4, O_FLT);
`endif
    step(0, 1, 1, 0); chk("tmo_idle", 3'd0, O_IDLE);

    // Asynchronous reset while in SETTLE, request still held.
    step(1, 1, 1, 0); chk("rst_evac", 3'd1, O_ACT);
    step(1, 1, 1, 1); chk("rst_settle", 3'd2, O_ACT);
    #2 Reset = 1'b0;
    #1 chk("rst_async_clear", 3'd0, O_IDLE);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1 chk("rst_restart", 3'd1, O_ACT);
    step(0, 1, 1, 1); chk("rst_abort", 3'd4, O_FLT);
    step(0, 1, 1, 1); chk("rst_idle", 3'd0, O_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
